// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     S,
  output logic                     Overflow,
  output logic                     Underflow,
  output logic                     Inexact
);

  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int unsigned EW = EXP_W + 2;
  localparam logic [EW-1:0] Bias = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ExpMax = {2'b00, {EXP_W{1'b1}}};

  typedef enum logic [1:0] {KindNorm, KindZero, KindInf, KindNan} kind_e;

  // Operand classification
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  kind_e            kind_in;

  assign ea = a[EXP_W+MAN_W-1 -: EXP_W];
  assign eb = b[EXP_W+MAN_W-1 -: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];

  always_comb begin
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
    kind_in = KindNorm;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      kind_in = KindNan;
    end else if (a_inf || b_inf) begin
      kind_in = KindInf;
    end else if (a_zero || b_zero) begin
      kind_in = KindZero;
    end
  end

  // One stall signal freezes every stage, bubbles included
  assign in_ready = !out_valid || out_ready;

  // Stage 1 and stage 2 registers
  logic                    s1_valid, s1_sign;
  logic [EXP_W-1:0]        s1_ea, s1_eb;
  logic [MAN_W:0]          s1_ma, s1_mb;
  kind_e                   s1_kind;
  logic                    s2_valid, s2_sign;
  logic [PW-1:0]           s2_prod;
  logic signed [EW-1:0]    s2_exp;
  kind_e                   s2_kind;

  // Stage 3 combinational normalise / round / pack
  logic [PW-2:0]           norm;
  logic signed [EW-1:0]    exp_n, exp_r;
  logic [MAN_W-1:0]        frac, frac_r;
  logic                    guard, rnd, sticky;
  logic [EXP_W+MAN_W:0]    res;
  logic                    res_ovf, res_unf, res_inx;
`ifdef FP_MUL_RNE_EN
  logic                    round_up;
  logic [MAN_W:0]          frac_ext;
`endif

  always_comb begin
    norm   = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
    exp_n  = s2_exp + EW'(s2_prod[PW-1]);
    frac   = norm[PW-2 -: MAN_W];
    guard  = norm[MAN_W];
    rnd    = norm[MAN_W-1];
    sticky = |norm[MAN_W-2:0];
`ifdef FP_MUL_RNE_EN
    round_up = guard && (rnd || sticky || frac[0]);
    frac_ext = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    frac_r   = frac_ext[MAN_W-1:0];
    exp_r    = exp_n + EW'(frac_ext[MAN_W]);
`else
    frac_r   = frac;
    exp_r    = exp_n;
`endif
    res     = '0;
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_inx = 1'b0;
    case (s2_kind)
      KindNan:  res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      KindInf:  res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      KindZero: res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (exp_r >= ExpMax) begin
          res     = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          res_ovf = 1'b1;
          res_inx = 1'b1;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
          res     = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
          res_unf = 1'b1;
          res_inx = 1'b1;
        end else begin
          res     = {s2_sign, exp_r[EXP_W-1:0], frac_r};
          res_inx = guard || rnd || sticky;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_ea     <= '0;
      s1_eb     <= '0;
      s1_ma     <= '0;
      s1_mb     <= '0;
      s1_kind   <= KindZero;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_prod   <= '0;
      s2_exp    <= '0;
      s2_kind   <= KindZero;
      out_valid <= 1'b0;
      S         <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      Inexact   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
        s1_ea   <= ea;
        s1_eb   <= eb;
        s1_ma   <= {1'b1, fa};
        s1_mb   <= {1'b1, fb};
        s1_kind <= kind_in;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_prod <= PW'(s1_ma) * PW'(s1_mb);
        s2_exp  <= {2'b00, s1_ea} + {2'b00, s1_eb} - Bias;
        s2_kind <= s1_kind;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        S         <= res;
        Overflow  <= res_ovf;
        Underflow <= res_unf;
        Inexact   <= res_inx;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomised and directed bench for fp_mul_pipe using a real-arithmetic reference model.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Overflow, Underflow, Inexact;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Inexact   (Inexact)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    for (int i = 0; i < n; i++) r = r * 2.0;
    for (int i = 0; i < -n; i++) r = r * 0.5;
    return r;
  endfunction

  // Result as {S, Overflow, Underflow, Inexact}; normal products are exact in double precision
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
    int          ex, ey, e;
    int          fx, fy;
    logic        xz, xi, xn, yz, yi, yn, sgn, ix;
    real         p;
    logic [63:0] bits;
    logic [22:0] fr;
    logic [28:0] disc;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    fx  = int'(x[22:0]);
    fy  = int'(y[22:0]);
    xz  = (ex == 0);
    yz  = (ey == 0);
    xi  = (ex == 255) && (fx == 0);
    yi  = (ey == 255) && (fy == 0);
    xn  = (ex == 255) && (fx != 0);
    yn  = (ey == 255) && (fy != 0);
    sgn = x[31] ^ y[31];
    if (xn || yn || (xi && yz) || (xz && yi)) return {32'h7FC00000, 3'b000};
    if (xi || yi) return {sgn, 8'hFF, 23'h0, 3'b000};
    if (xz || yz) return {sgn, 31'h0, 3'b000};
    p = (1.0 + real'(fx) / 8388608.0) * pow2(ex - 127) *
        (1.0 + real'(fy) / 8388608.0) * pow2(ey - 127);
    bits = $realtobits(p);
    e    = int'(bits[62:52]) - 1023 + 127;
    fr   = bits[51:29];
    disc = bits[28:0];
    ix   = |disc;
`ifdef FP_MUL_RNE_EN
    if (disc[28] && ((|disc[27:0]) || fr[0])) begin
      if (fr == 23'h7FFFFF) begin
        fr = '0;
        e  = e + 1;
      end else begin
        fr = fr + 23'd1;
      end
    end
`endif
    if (e >= 255) return {sgn, 8'hFF, 23'h0, 3'b101};
    if (e <= 0) return {sgn, 31'h0, 3'b011};
    return {sgn, e[7:0], fr, 2'b00, ix};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 15))
      0:       e = 8'h00;
      1:       e = 8'hFF;
      2, 3:    e = 8'($urandom_range(0, 255));
      default: e = 8'($urandom_range(97, 157));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle
  logic [34:0] exp_q[$];
  logic        hold_pend = 1'b0;
  logic [34:0] held;

  always @(negedge clk) begin
    logic [34:0] e;
    if (!reset) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      if (hold_pend) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'({S, Overflow, Underflow, Inexact}), 64'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'(out_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'({S, Overflow, Underflow, Inexact}), 64'(e));
          n_out++;
        end
      end
      hold_pend = out_valid && !out_ready;
      held      = {S, Overflow, Underflow, Inexact};
      if (in_valid && in_ready) exp_q.push_back(model(a, b));
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int   guard;
    logic ok;
    guard    = 0;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!ok && guard < 100);
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $fatal(1, "input handshake stuck");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  logic [31:0] dir_a [10] = '{32'h3FC00000, 32'hC0000000, 32'h3FC00001, 32'h7F000000,
                              32'h00800000, 32'h7F800000, 32'hFF800000, 32'h80000000,
                              32'h7FC12345, 32'h00000000};
  logic [31:0] dir_b [10] = '{32'h40000000, 32'h3F800000, 32'h3FC00001, 32'h7F000000,
                              32'h3F000000, 32'h00000000, 32'h40000000, 32'h3F800000,
                              32'h3F800000, 32'hFF800000};
  logic [34:0] dir_e [10] = '{{32'h40400000, 3'b000}, {32'hC0000000, 3'b000},
`ifdef FP_MUL_RNE_EN
                              {32'h40100002, 3'b001},
`else
                              {32'h40100001, 3'b001},
`endif
                              {32'h7F800000, 3'b101}, {32'h00000000, 3'b011},
                              {32'h7FC00000, 3'b000}, {32'hFF800000, 3'b000},
                              {32'h80000000, 3'b000}, {32'h7FC00000, 3'b000},
                              {32'h7FC00000, 3'b000}};

  initial begin
    int lat;
    int n0;
    bit rnd_done;
    reset     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", 64'({out_valid, S, Overflow, Underflow, Inexact, in_ready}),
          64'({1'b0, 32'h0, 3'b000, 1'b1}));
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Directed vectors, one at a time, with latency measurement
    for (int i = 0; i < 10; i++) begin
      send(dir_a[i], dir_b[i]);
      lat = 1;
      while (lat < 10) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        #1;
        lat++;
      end
      check($sformatf("latency_%0d", i), 64'(lat), 64'(3));
      check($sformatf("directed_%0d", i), 64'({S, Overflow, Underflow, Inexact}), 64'(dir_e[i]));
      @(posedge clk);
      #1;
    end

    // Eight back-to-back pairs with the consumer stalling for three cycles
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), rand_op());
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stream_count", 64'(n_out - n0), 64'(8));

    // Random traffic with random back-pressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join
    drain();

    // Reset with two products in flight
    send(32'h3FC00000, 32'h40000000);
    send(32'h40000000, 32'h40000000);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("reset_flight", 64'({out_valid, S, Overflow, Underflow, Inexact}), 64'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale", 64'(out_valid), 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
# fp_mul_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshaking, configurable exponent and mantissa widths, special-value handling and status flags. It replaces the single-precision, single-register multiplier in the arithmetic datapath and sits between the operand-issue logic and the result writeback stage. Throughput is one product per cycle when the consumer is not stalling.

## Interface
- EXP_W, 8: exponent width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored fraction width; implicit leading 1 for normal operands.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair a/b present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}.
- b  in  1+EXP_W+MAN_W  operand B.
- out_valid  out  1  result S and flags valid.
- out_ready  in  1  consumer takes result this cycle.
- S  out  1+EXP_W+MAN_W  product.
- Overflow  out  1  result saturated to ±inf by exponent overflow.
- Underflow  out  1  result flushed to ±0 (exponent below 1 after rounding).
- Inexact  out  1  discarded product bits non-zero, or overflow/underflow.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Global stall: in_ready = !out_valid || out_ready; when in_ready=0 every stage holds; when 1 all stages advance, bubbles included.
- Stage 1: register operands, sign = a.sign ^ b.sign, classify each as zero (exp=0, subnormals treated as zero), inf (exp all-ones, frac=0), NaN (exp all-ones, frac≠0), normal.
- Stage 2: (MAN_W+1)x(MAN_W+1) unsigned product (2*MAN_W+2 bits); exponent sum e = ea+eb-bias in signed EXP_W+2 bits.
- Stage 3: normalise (product MSB set → shift right 1, e+1); round; mantissa carry-out on rounding → e+1; pack; flags.
- Priority of results: NaN in, or inf×zero → canonical qNaN {0, all-ones, 1 then zeros}, flags 0. Else inf operand → signed inf, flags 0. Else zero operand → signed zero, flags 0. Else e ≥ 2^EXP_W-1 → signed inf, Overflow=1, Inexact=1. Else e ≤ 0 → signed zero, Underflow=1, Inexact=1. Else normal result.
- Flags accompany their result; they are not sticky.

## Timing
- Latency 3 cycles from input transfer to out_valid with out_ready held high.
- Reset (reset=0 at a rising edge): all stage valid bits 0, out_valid=0, S=0, Overflow=Underflow=Inexact=0; in_ready=1 the first cycle after reset. Reset mid-operation discards all in-flight products; none emerge afterwards.
- S and flags stay stable while out_valid=1 and out_ready=0.
- Simultaneous output transfer and input transfer in the same cycle is legal; no bubble inserted.
- in_ready depends combinationally on out_ready; no other comb path input→output.

## Configuration
- FP_MUL_RNE_EN defined: round-to-nearest-even using guard, round and sticky bits; ties round to even fraction.
- Undefined: truncation (round toward zero); Inexact still reports discarded non-zero bits. Rounding carry logic removed.

## Test plan
- Default params, 0x3FC00000 × 0x40000000 → after 3 cycles S=0x40400000, all flags 0; 0xC0000000 × 0x3F800000 → 0xC0000000.
- 0x3FC00001 × 0x3FC00001 → with FP_MUL_RNE_EN S=0x40100002, without S=0x40100001; Inexact=1 both.
- 0x7F000000 × 0x7F000000 → S=0x7F800000, Overflow=1, Inexact=1; 0x00800000 × 0x3F000000 → S=0x00000000, Underflow=1.
- 0x7F800000 × 0x00000000 → S=0x7FC00000; 0xFF800000 × 0x40000000 → S=0xFF800000, flags 0; 0x80000000 × 0x3F800000 → S=0x80000000.
- Stream 8 back-to-back pairs, out_ready low for cycles 4-6 → in_ready low during stall, results in order, none lost or duplicated, S stable while stalled.
- Assert reset=0 with 2 products in flight → next cycle out_valid=0, S=0, flags 0; no stale result later.
